// File: rtl/i2s_rx_frame_ctrl.sv
// I2S master-receive sequencer: derives SCK/WS from clk_i, shifts in
// DATA_BITS-wide samples from SD for each slot, and presents them on a
// valid/ready interface with a sticky overflow flag for dropped samples.
module i2s_rx_frame_ctrl #(
    parameter int SCK_DIV       = 8,
    parameter int BITS_PER_SLOT = 32,
    parameter int DATA_BITS     = 24
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 sd_i,
    input  logic                 clr_ovf_i,
    input  logic                 ready_i,
    output logic                 sck_o,
    output logic                 ws_o,
    output logic [DATA_BITS-1:0] sample_o,
    output logic                 left_o,
    output logic                 valid_o,
    output logic                 overflow_o,
    output logic                 busy_o
);

    localparam int DW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int BW = (BITS_PER_SLOT > 1) ? $clog2(BITS_PER_SLOT) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_SLOT - 1);
    localparam logic [BW-1:0] BIT_DATA = BW'(DATA_BITS);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t                 state;
    logic [DW-1:0]          div_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic [DATA_BITS-1:0]   shifted;
    logic                   running, tc, rise_evt, fall_evt;
    logic                   slot_end, frame_end, capture, complete, drop;

    assign running   = (state != IDLE);
    assign tc        = running && (div_cnt == DIV_LAST);
    assign rise_evt  = tc && !sck_o;
    assign fall_evt  = tc && sck_o;
    assign slot_end  = fall_evt && (bit_cnt == BIT_LAST);
    // End of the right slot: the falling edge where WS would return to 0
    assign frame_end = slot_end && ws_o;
    // Bit 0 of each slot is the I2S delay bit; bits past DATA_BITS are padding
    assign capture   = rise_evt && (bit_cnt != '0) && (bit_cnt <= BIT_DATA);
    assign complete  = rise_evt && (bit_cnt == BIT_DATA);
    assign shifted   = {shreg[DATA_BITS-2:0], sd_i};
    assign drop      = complete && valid_o && !ready_i;

    // Run/stop sequencing, SCK divider, bit counter, WS and the capture shifter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            sck_o   <= 1'b0;
            ws_o    <= 1'b0;
            busy_o  <= 1'b0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    sck_o   <= 1'b0;
                    ws_o    <= 1'b0;
                    if (en_i) begin
                        state  <= RUN;
                        busy_o <= 1'b1;
                    end
                end
                RUN, STOP: begin
                    if (state == STOP && frame_end) begin
                        state   <= IDLE;
                        busy_o  <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        sck_o   <= 1'b0;
                        ws_o    <= 1'b0;
                    end else begin
                        // Dropping en_i lets the current frame finish
                        if (state == RUN && !en_i)
                            state <= STOP;
                        if (tc) begin
                            div_cnt <= '0;
                            sck_o   <= ~sck_o;
                        end else begin
                            div_cnt <= div_cnt + DW'(1);
                        end
                        if (fall_evt) begin
                            bit_cnt <= slot_end ? '0 : bit_cnt + BW'(1);
                            if (slot_end)
                                ws_o <= ~ws_o;
                        end
                        if (capture)
                            shreg <= shifted;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output holding register: load when empty or draining, else drop and flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sample_o   <= '0;
            left_o     <= 1'b0;
            valid_o    <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            if (complete && (!valid_o || ready_i)) begin
                sample_o <= shifted;
                left_o   <= ~ws_o;
                valid_o  <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            // A drop in the same cycle as a clear leaves the flag set
            if (drop)
                overflow_o <= 1'b1;
            else if (clr_ovf_i)
                overflow_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_rx_frame_ctrl.sv
// Bench for i2s_rx_frame_ctrl. The reference derives SCK/WS/sample timing
// arithmetically from the number of cycles since RUN was entered, and acts
// as the codec by driving SD from per-slot sample words.
module tb_i2s_rx_frame_ctrl;

    localparam int D    = 2;
    localparam int BPS  = 32;
    localparam int DB   = 24;
    localparam int PER  = 2 * D;
    localparam int FRM  = 2 * BPS * PER;

    logic          clk_i = 1'b0;
    logic          rst_i, en_i, sd_i, clr_ovf_i, ready_i;
    logic          sck_o, ws_o, left_o, valid_o, overflow_o, busy_o;
    logic [DB-1:0] sample_o;

    i2s_rx_frame_ctrl #(.SCK_DIV(D), .BITS_PER_SLOT(BPS), .DATA_BITS(DB)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .sd_i(sd_i),
        .clr_ovf_i(clr_ovf_i), .ready_i(ready_i), .sck_o(sck_o), .ws_o(ws_o),
        .sample_o(sample_o), .left_o(left_o), .valid_o(valid_o),
        .overflow_o(overflow_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int nchk = 0;
    int nerr = 0;
    string phase = "reset";

    // reference state
    logic          m_run, m_stop, m_valid, m_left, m_ovf;
    logic [DB-1:0] m_sample;
    int            k;
    logic [DB-1:0] words [64];
    logic          clr_req, clr_on_comp, comp_now;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s/%s: got %h expected %h at %0t", phase, tag, got, exp, $time);
        end
    endtask

    task automatic reshuffle();
        for (int i = 0; i < 64; i++) words[i] = DB'($urandom);
    endtask

    // One clock: drive and check at the falling edge, then advance the reference
    task automatic tick();
        int p, b, s;
        logic e_sck, e_ws, drop;
        @(negedge clk_i);
        p = k / PER;
        b = p % BPS;
        s = p / BPS;
        comp_now = m_run && (k % PER == D - 1) && (b == DB);
        if (m_run && b >= 1 && b <= DB) sd_i = words[s % 64][DB - b];
        else                            sd_i = 1'($urandom);
        clr_ovf_i = clr_req || (clr_on_comp && comp_now);
        e_sck = m_run ? 1'((k / D) % 2) : 1'b0;
        e_ws  = m_run ? 1'(s % 2) : 1'b0;
        chk("pins", 64'({sck_o, ws_o, busy_o}), 64'({e_sck, e_ws, m_run}));
        chk("stream", 64'({valid_o, left_o, overflow_o, sample_o}),
            64'({m_valid, m_left, m_ovf, m_sample}));
        @(posedge clk_i);
        #1;
        if (rst_i) begin
            m_run = 0; m_stop = 0; k = 0;
            m_valid = 0; m_left = 0; m_ovf = 0; m_sample = '0;
            reshuffle();
        end else begin
            drop = comp_now && m_valid && !ready_i;
            if (comp_now && (!m_valid || ready_i)) begin
                m_valid = 1; m_sample = words[s % 64]; m_left = (s % 2 == 0);
            end else if (m_valid && ready_i) begin
                m_valid = 0;
            end
            if (drop) m_ovf = 1;
            else if (clr_ovf_i) m_ovf = 0;
            if (m_run) begin
                if (m_stop && (k % PER == PER - 1) && (b == BPS - 1) && (s % 2 == 1)) begin
                    m_run = 0;
                end else begin
                    if (!m_stop && !en_i) m_stop = 1;
                    k++;
                end
            end else if (en_i) begin
                m_run = 1; m_stop = 0; k = 0;
            end
        end
    endtask

    initial begin
        m_run = 0; m_stop = 0; m_valid = 0; m_left = 0; m_ovf = 0; m_sample = '0; k = 0;
        clr_req = 0; clr_on_comp = 0; comp_now = 0;
        reshuffle();
        rst_i = 1; en_i = 1; ready_i = 1; sd_i = 0; clr_ovf_i = 0;

        // reset held with en_i high: everything stays 0
        repeat (3) tick();
        rst_i = 0;
        words[0] = 24'hA5A5A5;
        words[1] = 24'h5A5A5A;

        // free run, consumer always ready
        phase = "stream";
        repeat (2 * FRM + 8) tick();

        // one frame with no consumer: left held, right dropped
        phase = "backpressure";
        for (int i = 0; i < 2 * FRM && !(m_run && k % FRM == 0); i++) tick();
        ready_i = 0;
        repeat (FRM) tick();
        ready_i = 1;
        repeat (10) tick();
        phase = "clear";
        clr_req = 1; tick(); clr_req = 0;
        repeat (4) tick();

        // clear coincident with every completion while blocked
        phase = "clr_vs_drop";
        clr_on_comp = 1; ready_i = 0;
        repeat (FRM) tick();
        clr_on_comp = 0; ready_i = 1;
        repeat (10) tick();
        clr_req = 1; tick(); clr_req = 0;

        // randomized consumer and clears
        phase = "random";
        for (int i = 0; i < 2 * FRM; i++) begin
            ready_i = ($urandom_range(0, 2) != 0);
            clr_req = ($urandom_range(0, 39) == 0);
            tick();
        end
        clr_req = 0; ready_i = 1;

        // stop request in the middle of the left slot
        phase = "stop";
        for (int i = 0; i < 2 * FRM && !(m_run && k % FRM == 40); i++) tick();
        en_i = 0;
        repeat (FRM + 100) tick();

        // restart, then reset at bit 12 of a left slot
        phase = "midreset";
        en_i = 1;
        for (int i = 0; i < 2 * FRM && !(m_run && k % FRM == 12 * PER + 2); i++) tick();
        rst_i = 1;
        repeat (2) tick();
        rst_i = 0;
        phase = "realign";
        repeat (FRM + 20) tick();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
